prog_loader: RTL and testbench

PROG_LOADER -- requirements
Module: prog_loader

---
 rtl/prog_loader_pkg.sv | 19 +
 rtl/prog_loader.sv | 128 ++++++++++++
 tb/tb_prog_loader.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/prog_loader_pkg.sv
// Shared CPU-side definitions for the program loader.
// Holds the loader FSM state encoding, default memory geometry and the
// CPU data-bus width.
package prog_loader_pkg;

  localparam int BUS_W      = 8;   // CPU data bus width
  localparam int DEF_DEPTH  = 16;  // default program memory depth (words)
  localparam int DEF_ADDR_W = 4;   // default address width, clog2(DEF_DEPTH)

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_ADDR = 3'd2,
    S_DATA = 3'd3,
    S_DONE = 3'd4,
    S_ERR  = 3'd5
  } ld_state_e;

endpackage

// File: rtl/prog_loader.sv
// prog_loader: streams program bytes into CPU memory over the shared bus.
// Each accepted byte becomes two bus cycles: the address is driven with
// mar_load, then the byte is driven with ram_we.  The CPU clock is held
// (cpu_hold) for the whole session.
//
// Ports
//   clk, rst_n      clock, async active-low reset
//   start           one-cycle pulse, opens a session at address 0
//   in_valid/in_data/in_last, in_ready   byte stream handshake
//   bus_en, bus_out CPU bus drive (loader has top bus priority)
//   mar_load        MAR captures bus
//   ram_we          RAM writes bus at MAR
//   cpu_hold        gates CPU clock during a session
//   done            one-cycle pulse, session ended on in_last
//   error           high after an overflow until the next start
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int DEPTH  = DEF_DEPTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [BUS_W-1:0] in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic             bus_en,
  output logic [BUS_W-1:0] bus_out,
  output logic             mar_load,
  output logic             ram_we,
  output logic             cpu_hold,
  output logic             done,
  output logic             error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ld_state_e         state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic [BUS_W-1:0]  hold_data, hold_data_nxt;
  logic              hold_last, hold_last_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      addr      <= '0;
      hold_data <= '0;
      hold_last <= 1'b0;
    end else begin
      state     <= state_nxt;
      addr      <= addr_nxt;
      hold_data <= hold_data_nxt;
      hold_last <= hold_last_nxt;
    end
  end

  // Outputs are decoded purely from state and the holding registers, so an
  // asynchronous reset forces them all low without waiting for a clock.
  always_comb begin
    state_nxt     = state;
    addr_nxt      = addr;
    hold_data_nxt = hold_data;
    hold_last_nxt = hold_last;
    in_ready      = 1'b0;
    bus_en        = 1'b0;
    bus_out       = '0;
    mar_load      = 1'b0;
    ram_we        = 1'b0;
    cpu_hold      = 1'b0;
    done          = 1'b0;
    error         = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = S_WAIT;
          addr_nxt  = '0;
        end
      end
      S_WAIT: begin
        in_ready = 1'b1;
        cpu_hold = 1'b1;
        if (in_valid) begin
          hold_data_nxt = in_data;
          hold_last_nxt = in_last;
          state_nxt     = S_ADDR;
        end
      end
      S_ADDR: begin
        cpu_hold  = 1'b1;
        bus_en    = 1'b1;
        mar_load  = 1'b1;
        bus_out   = BUS_W'(addr);
        state_nxt = S_DATA;
      end
      S_DATA: begin
        cpu_hold = 1'b1;
        bus_en   = 1'b1;
        ram_we   = 1'b1;
        bus_out  = hold_data;
        // Never step past the top word: the counter must not wrap to 0 and
        // the next session reloads it from start anyway.
        if (addr != LAST_ADDR) addr_nxt = addr + 1'b1;
        if (hold_last)              state_nxt = S_DONE;
        else if (addr == LAST_ADDR) state_nxt = S_ERR;
        else                        state_nxt = S_WAIT;
      end
      S_DONE: begin
        cpu_hold  = 1'b1;
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERR: begin
        // Stays here (CPU still held) until a fresh start re-opens a session.
        cpu_hold = 1'b1;
        error    = 1'b1;
        if (start) begin
          state_nxt = S_WAIT;
          addr_nxt  = '0;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader.  A small CPU-side model (MAR + RAM) is
// driven from the DUT bus strobes; memory contents, address sequence,
// done/error behaviour and per-cycle bus invariants are checked.
module tb_prog_loader;
  import prog_loader_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, start, in_valid, in_last;
  logic [7:0] in_data;
  logic       in_ready, bus_en, mar_load, ram_we, cpu_hold, done, error;
  logic [7:0] bus_out;

  prog_loader #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid),
    .in_data(in_data), .in_last(in_last), .in_ready(in_ready),
    .bus_en(bus_en), .bus_out(bus_out), .mar_load(mar_load),
    .ram_we(ram_we), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // CPU memory model and event logs, sampled mid-cycle
  logic [7:0] mem [0:255];
  logic [7:0] mar = 8'h0;
  logic [7:0] mar_log [0:1023];
  logic [7:0] wr_log  [0:1023];
  int mar_cnt = 0, wr_cnt = 0, done_cnt = 0, hold_drop = 0;
  int cyc = 0, first_cyc = 0, done_cyc = 0, fall_cyc = 0;
  logic hold_q = 1'b0, done_q = 1'b0;

  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;

  always @(negedge clk) begin
    chk("excl_strobe", {31'd0, mar_load & ram_we}, 0);
    chk("bus_en_eq", {31'd0, bus_en}, {31'd0, mar_load | ram_we});
    if (!cpu_hold) chk("idle_rdy", {31'd0, in_ready}, 0);
    if (mar_load) begin
      mar = bus_out;
      mar_log[mar_cnt % 1024] = bus_out;
      mar_cnt++;
    end
    if (ram_we) begin
      mem[mar] = bus_out;
      wr_log[wr_cnt % 1024] = mar;
      wr_cnt++;
    end
    if (cpu_hold && !hold_q) first_cyc = cyc;
    if (!cpu_hold && hold_q) begin
      fall_cyc = cyc;
      if (!done_q) hold_drop++;
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    hold_q = cpu_hold;
    done_q = done;
    cyc++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present a byte after 'gap' idle cycles; returns #1 after the accepting edge.
  task automatic send(input logic [7:0] d, input logic l, input int gap);
    int n;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) begin @(posedge clk); #1; break; end
      n++;
      if (n > 50) begin chk("send_ready", {31'd0, in_ready}, 1); break; end
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    do begin @(negedge clk); n++; end while (cpu_hold && n < 100);
    chk("wait_idle", {31'd0, cpu_hold}, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rdy"},  {31'd0, in_ready}, 0);
    chk({tag, "_bus"},  {31'd0, bus_en},   0);
    chk({tag, "_out"},  {24'd0, bus_out},  0);
    chk({tag, "_mar"},  {31'd0, mar_load}, 0);
    chk({tag, "_we"},   {31'd0, ram_we},   0);
    chk({tag, "_hold"}, {31'd0, cpu_hold}, 0);
    chk({tag, "_done"}, {31'd0, done},     0);
    chk({tag, "_err"},  {31'd0, error},    0);
  endtask

  logic [7:0] b4_data [0:4];
  int         b4_gap  [0:4];
  int w0, m0, d0, h0;

  initial begin
    b4_data[0] = 8'h11; b4_data[1] = 8'h22; b4_data[2] = 8'h33;
    b4_data[3] = 8'h44; b4_data[4] = 8'h55;
    b4_gap[0] = 3; b4_gap[1] = 0; b4_gap[2] = 5; b4_gap[3] = 1; b4_gap[4] = 2;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = 8'h0; in_last = 1'b0;
    #3;
    chk_all_zero("rst");
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // in_valid while idle: no handshake, no write
    in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    in_valid = 1'b0;
    chk("idle_nowr", wr_cnt, 0);

    // three-byte load, in_valid held high
    w0 = wr_cnt; m0 = mar_cnt; d0 = done_cnt; h0 = hold_drop;
    do_start();
    send(8'h1A, 1'b0, 0);
    send(8'h2B, 1'b0, 0);
    send(8'hE0, 1'b1, 0);
    in_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 3; i++) chk("t1_mar", {24'd0, mar_log[m0 + i]}, i);
    chk("t1_m0", {24'd0, mem[0]}, 32'h1A);
    chk("t1_m1", {24'd0, mem[1]}, 32'h2B);
    chk("t1_m2", {24'd0, mem[2]}, 32'hE0);
    chk("t1_wr", wr_cnt - w0, 3);
    chk("t1_done", done_cnt - d0, 1);
    chk("t1_lat", done_cyc - first_cyc, 9);
    chk("t1_holdfall", fall_cyc - done_cyc, 1);
    chk("t1_hold", hold_drop - h0, 0);
    chk("t1_err", {31'd0, error}, 0);

    // exactly DEPTH bytes, last on the 16th
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    for (int i = 0; i < 16; i++) send(8'h40 + 8'(i), (i == 15), 0);
    in_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 16; i++) chk("t2_mem", {24'd0, mem[i]}, 32'h40 + i);
    for (int i = 0; i < 16; i++) chk("t2_addr", {24'd0, wr_log[w0 + i]}, i);
    chk("t2_wr", wr_cnt - w0, 16);
    chk("t2_done", done_cnt - d0, 1);
    chk("t2_err", {31'd0, error}, 0);

    // overflow: 16 bytes without in_last
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    for (int i = 0; i < 16; i++) send(8'hA0 + 8'(i), 1'b0, 0);
    in_data = 8'hC0;
    repeat (6) @(negedge clk);
    chk("t3_err", {31'd0, error}, 1);
    chk("t3_hold", {31'd0, cpu_hold}, 1);
    chk("t3_rdy", {31'd0, in_ready}, 0);
    chk("t3_wr", wr_cnt - w0, 16);
    chk("t3_m15", {24'd0, mem[15]}, 32'hAF);
    chk("t3_lastaddr", {24'd0, wr_log[w0 + 15]}, 15);
    chk("t3_done", done_cnt - d0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    do_start();
    @(negedge clk);
    chk("t3_errclr", {31'd0, error}, 0);
    chk("t3_rdy2", {31'd0, in_ready}, 1);
    @(posedge clk); #1;
    send(8'h5C, 1'b1, 0);
    in_valid = 1'b0;
    wait_idle();
    chk("t3_m0", {24'd0, mem[0]}, 32'h5C);
    chk("t3_err2", {31'd0, error}, 0);

    // bursty in_valid
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    for (int i = 0; i < 5; i++) send(b4_data[i], (i == 4), b4_gap[i]);
    in_valid = 1'b0;
    wait_idle();
    for (int i = 0; i < 5; i++) chk("t4_mem", {24'd0, mem[i]}, {24'd0, b4_data[i]});
    chk("t4_wr", wr_cnt - w0, 5);
    chk("t4_done", done_cnt - d0, 1);

    // reset during the DATA cycle of the second byte
    w0 = wr_cnt; d0 = done_cnt;
    do_start();
    send(8'h91, 1'b0, 0);
    send(8'h92, 1'b0, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("t5_indata", {31'd0, ram_we}, 1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t5");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("t5_wr", wr_cnt - w0, 1);
    chk("t5_m1", {24'd0, mem[1]}, 32'h22);
    chk("t5_done", done_cnt - d0, 0);
    chk("t5_hold", {31'd0, cpu_hold}, 0);
    chk("t5_rdy", {31'd0, in_ready}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
